// File: rtl/serial_adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder_ctrl_pkg
// Purpose : Shared definitions for the bit-serial adder sequencer: default
//           operand width and the FSM state encodings.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package serial_adder_ctrl_pkg;

    // Default operand/sum width.
    localparam int SA_WIDTH_DEFAULT = 8;

    // Sequencer states; encodings are fixed so that external tooling and
    // waveform viewers see stable values.
    typedef enum logic [1:0] {
        SA_IDLE  = 2'd0,
        SA_SHIFT = 2'd1,
        SA_DONE  = 2'd2
    } sa_state_t;

endpackage : serial_adder_ctrl_pkg
`default_nettype wire

// File: rtl/add1bit.sv
`default_nettype none
// ============================================================================
// Module  : add1bit
// Purpose : Single-bit full-adder cell, purely combinational.
// Ports   : a, b   - addend bits
//           c_in   - carry in
//           s      - sum bit
//           c_out  - carry out
// Revision: 1.0 - initial release
// ============================================================================
module add1bit (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule : add1bit
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder_ctrl
// Purpose : Bit-serial WIDTH-bit adder. Operands are accepted over a
//           valid/ready handshake, summed one bit per clock (LSB first)
//           through a single add1bit cell, and the result is presented over
//           a second valid/ready handshake.
// Ports   : clk        - clock, rising edge
//           rst_n      - asynchronous active-low reset
//           in_valid   - operands a, b, c_in valid
//           in_ready   - block can accept operands (IDLE only)
//           a, b       - WIDTH-bit operands
//           c_in       - initial carry-in
//           out_valid  - sum/c_out valid, held until accepted
//           out_ready  - consumer accepts result
//           sum        - low WIDTH bits of a + b + c_in
//           c_out      - carry out of the MSB
//           busy       - high while shifting
//           ovf        - signed overflow (only with SERIAL_ADDER_OVERFLOW_EN)
// Config  : `define SERIAL_ADDER_OVERFLOW_EN adds the ovf output.
// Revision: 1.0 - initial release
// ============================================================================
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
`ifdef SERIAL_ADDER_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

    sa_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;

    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_sum_next;

    add1bit u_add1bit (
        .a     (r_a_sh[0]),
        .b     (r_b_sh[0]),
        .c_in  (r_carry),
        .s     (w_s),
        .c_out (w_co)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts the LSB
    // computed first has arrived at bit 0.
    assign w_sum_next = {w_s, r_sum_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= SA_IDLE;
            r_cnt     <= '0;
            r_carry   <= 1'b0;
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_sum_sh  <= '0;
            sum       <= '0;
            c_out     <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            ovf       <= 1'b0;
`endif
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (r_state)
                SA_IDLE: begin
                    if (in_valid) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_carry  <= c_in;
                        r_cnt    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= SA_SHIFT;
                    end
                end

                SA_SHIFT: begin
                    r_sum_sh <= w_sum_next;
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_carry  <= w_co;
                    if (r_cnt == C_LAST_BIT) begin
                        // Last bit: publish the result on the same edge.
                        sum       <= w_sum_next;
                        c_out     <= w_co;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        // r_carry here is the carry into the MSB position.
                        ovf       <= r_carry ^ w_co;
`endif
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        r_state   <= SA_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                SA_DONE: begin
                    // in_ready rises only after the result handshake, so a
                    // new operand can never be taken in the same cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= SA_IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    r_state   <= SA_IDLE;
                end
            endcase
        end
    end

endmodule : serial_adder_ctrl
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_adder_ctrl
// Purpose : Self-checking bench for serial_adder_ctrl (WIDTH = 8). Directed
//           operands are driven through the input handshake; expected
//           results are queued and compared by a monitor on every
//           out_valid && out_ready cycle.
// Config  : honours `define SERIAL_ADDER_OVERFLOW_EN (checks ovf).
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             busy;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             ovf;
`endif

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
`ifdef SERIAL_ADDER_OVERFLOW_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             c_out;
        logic             ovf;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every result handshake against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_result: got sum=0x%0h c_out=%0b expected none", sum, c_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sum", 32'(sum), 32'(e.sum));
                chk("c_out", 32'(c_out), 32'(e.c_out));
`ifdef SERIAL_ADDER_OVERFLOW_EN
                chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // Drive one request and return just after the accept edge.
    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tc, input logic push,
                        input logic [WIDTH-1:0] es, input logic eco, input logic eov);
        int n;
        exp_t e;
        a = ta; b = tb; c_in = tc; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            n_vec++; n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
        e.sum = es; e.c_out = eco; e.ovf = eov;
        if (push) q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(posedge clk); #1; n++;
        end
        if (q.size() != 0) begin
            n_vec++; n_fail++;
            $display("FAIL result_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0;

        // 1. Reset values
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_c_out", 32'(c_out), 32'd0);

        // 2. Zero operands plus latency (accept edge counted as cycle 1)
        send(8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", 32'(n), 32'd9);
        drain();

        // 3..4. Carry and signed-overflow corners
        send(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0); drain();
        send(8'h7F, 8'h00, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1); drain();
        send(8'h80, 8'h80, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1); drain();
        send(8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0); drain();

        // 5. Request during SHIFT is ignored; result held without out_ready
        out_ready = 1'b0;
        send(8'h0F, 8'h01, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 a = 8'h11; b = 8'h00; in_valid = 1'b1;
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_sum", 32'(sum), 32'h10);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain();
        repeat (3) @(posedge clk); #1;
        chk("idle_after_ignore", 32'(in_ready), 32'd1);

        // 6. Asynchronous reset mid-SHIFT (counter = 3)
        send(8'h33, 8'h44, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_c_out", 32'(c_out), 32'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk("abort_ovf", 32'(ovf), 32'd0);
`endif
        @(posedge clk); #1 rst_n = 1'b1;
        send(8'hA5, 8'h5A, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0); drain();

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_serial_adder_ctrl
`default_nettype wire
